// File: rtl/tappy_rx.sv
// tappy_rx: synchronous-serial frame receiver (start, DATA_BITS LSB-first, optional parity, stop).
// Optional macro TAPPY_GLITCH_FILTER_EN adds a 3-sample majority filter on the synchronized clk.
`timescale 1ns/1ps

module tappy_rx #(
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 1,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 clk,
    input  logic                 dat,
    output logic [DATA_BITS-1:0] word,
    output logic                 done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 timeout,
    output logic                 busy
);

    // state    | meaning
    // S_IDLE   | waiting for a falling edge with dat=0 (start bit)
    // S_DATA   | shifting in DATA_BITS data bits
    // S_PARITY | capturing the parity bit
    // S_STOP   | waiting for the stop bit, frame result published next cycle
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    localparam int PAR_MODE = (PARITY == 3) ? 0 : PARITY;
    localparam int CW       = $clog2(DATA_BITS + 1);
    localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic                  r_clk_p;
    logic                  r_armed;
    logic                  w_clk_q;
    logic                  w_edge;
    logic                  w_frame_end;
    logic                  w_tmo_hit;
    logic [CW-1:0]         r_bit_cnt;
    logic [TW-1:0]         r_tmo_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_word;
    logic                  r_par_err;
    logic                  r_done, r_perr, r_ferr, r_timeout;

    // r_armed masks edge detection during the first cycle after reset release
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_armed  <= 1'b0;
        end else begin
            r_clk_s1 <= clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= dat;
            r_dat_s2 <= r_dat_s1;
            r_armed  <= 1'b1;
        end
    end

`ifdef TAPPY_GLITCH_FILTER_EN
    logic r_clk_h1, r_clk_h2, r_clk_f;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_h1 <= 1'b1;
            r_clk_h2 <= 1'b1;
            r_clk_f  <= 1'b1;
        end else begin
            r_clk_h1 <= r_clk_s2;
            r_clk_h2 <= r_clk_h1;
            r_clk_f  <= (r_clk_s2 & r_clk_h1) | (r_clk_s2 & r_clk_h2) | (r_clk_h1 & r_clk_h2);
        end
    end

    assign w_clk_q = r_clk_f;
`else
    assign w_clk_q = r_clk_s2;
`endif

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_clk_p <= 1'b1;
        else        r_clk_p <= w_clk_q;
    end

    assign w_edge = r_armed & r_clk_p & ~w_clk_q;

    // An edge in the same cycle as the timeout terminal count keeps the frame alive
    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        w_tmo_hit   = 1'b0;
        if ((r_state != S_IDLE) && !w_edge && (r_tmo_cnt == TMO_LAST)) begin
            w_state_nxt = S_IDLE;
            w_tmo_hit   = 1'b1;
        end else if (w_edge) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_dat_s2) w_state_nxt = S_DATA;
                end
                S_DATA: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        if (PAR_MODE != 0) w_state_nxt = S_PARITY;
                        else               w_state_nxt = S_STOP;
                    end
                end
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    w_frame_end = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_tmo_cnt <= '0;
            r_shift   <= '0;
            r_word    <= '0;
            r_par_err <= 1'b0;
            r_done    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_frame_end;
            r_timeout <= w_tmo_hit;

            if (w_frame_end) begin
                r_word <= r_shift;
                r_perr <= r_par_err;
                r_ferr <= ~r_dat_s2;
            end else begin
                r_perr <= 1'b0;
                r_ferr <= 1'b0;
            end

            if ((r_state == S_IDLE) || w_edge || w_tmo_hit)
                r_tmo_cnt <= '0;
            else if (r_tmo_cnt != TMO_LAST)
                r_tmo_cnt <= r_tmo_cnt + TW'(1);

            if (w_edge) begin
                case (r_state)
                    S_IDLE: begin
                        r_bit_cnt <= '0;
                        r_par_err <= 1'b0;
                    end
                    S_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end
                    S_PARITY: begin
                        if (PAR_MODE == 1) r_par_err <= ~(^{r_shift, r_dat_s2});
                        else               r_par_err <= ^{r_shift, r_dat_s2};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign word       = r_word;
    assign done       = r_done;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign timeout    = r_timeout;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_tappy_rx.sv
// Scoreboard bench for tappy_rx: an 8-bit odd-parity instance and a 12-bit no-parity instance.
`timescale 1ns/1ps

module tb_tappy_rx;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        clk8   = 1'b1;
    logic        dat8   = 1'b1;
    logic        clk12  = 1'b1;
    logic        dat12  = 1'b1;
    logic [7:0]  word8;
    logic [11:0] word12;
    logic        done8, perr8, ferr8, tmo8, busy8;
    logic        done12, perr12, ferr12, tmo12, busy12;

    typedef struct {
        logic [15:0] word;
        logic        perr;
        logic        ferr;
    } exp_t;

    exp_t q8[$];
    exp_t q12[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done8  = 0;
    int   n_done12 = 0;
    int   n_tmo8   = 0;

    tappy_rx #(.DATA_BITS(8), .PARITY(1), .TIMEOUT_CYCLES(2048)) u_dut (
        .sysclk(sysclk), .rst_n(rst_n), .clk(clk8), .dat(dat8),
        .word(word8), .done(done8), .parity_err(perr8), .frame_err(ferr8),
        .timeout(tmo8), .busy(busy8)
    );

    tappy_rx #(.DATA_BITS(12), .PARITY(0), .TIMEOUT_CYCLES(2048)) u_dut12 (
        .sysclk(sysclk), .rst_n(rst_n), .clk(clk12), .dat(dat12),
        .word(word12), .done(done12), .parity_err(perr12), .frame_err(ferr12),
        .timeout(tmo12), .busy(busy12)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge sysclk) begin
        exp_t e;
        if (done8) begin
            n_done8++;
            if (q8.size() == 0) chk("done8_unexpected", 1, 0);
            else begin
                e = q8.pop_front();
                chk("word8", {24'd0, word8}, {16'd0, e.word});
                chk("perr8", {31'd0, perr8}, {31'd0, e.perr});
                chk("ferr8", {31'd0, ferr8}, {31'd0, e.ferr});
            end
        end else if (perr8 | ferr8) chk("flags8_without_done", {30'd0, perr8, ferr8}, 0);
        if (tmo8) n_tmo8++;
        if (done12) begin
            n_done12++;
            if (q12.size() == 0) chk("done12_unexpected", 1, 0);
            else begin
                e = q12.pop_front();
                chk("word12", {20'd0, word12}, {16'd0, e.word});
                chk("perr12", {31'd0, perr12}, {31'd0, e.perr});
                chk("ferr12", {31'd0, ferr12}, {31'd0, e.ferr});
            end
        end else if (perr12 | ferr12) chk("flags12_without_done", {30'd0, perr12, ferr12}, 0);
        if (tmo12) chk("tmo12_unexpected", 1, 0);
    end

    function automatic logic odd_par(input logic [15:0] d, input int n);
        logic x = 1'b0;
        for (int i = 0; i < n; i++) x ^= d[i];
        return ~x;
    endfunction

    // seq[i] is the i-th bit on the wire; glitch_at inserts a one-sysclk clk low pulse after bit glitch_at
    task automatic send_bits(input bit sel12, input logic [31:0] seq, input int len,
                             input int half, input int glitch_at);
        for (int i = 0; i < len; i++) begin
            if (sel12) dat12 = seq[i]; else dat8 = seq[i];
            repeat (half) @(negedge sysclk);
            if (sel12) clk12 = 1'b0; else clk8 = 1'b0;
            repeat (half) @(negedge sysclk);
            if (sel12) clk12 = 1'b1; else clk8 = 1'b1;
            if (i == glitch_at) begin
                repeat (4) @(negedge sysclk);
                if (sel12) clk12 = 1'b0; else clk8 = 1'b0;
                @(negedge sysclk);
                if (sel12) clk12 = 1'b1; else clk8 = 1'b1;
            end
        end
        if (sel12) dat12 = 1'b1; else dat8 = 1'b1;
        repeat (half) @(negedge sysclk);
    endtask

    task automatic send_frame(input bit sel12, input logic [15:0] data, input int nbits,
                              input bit has_par, input logic par, input logic stop,
                              input int half, input int glitch_at);
        logic [31:0] seq = '0;
        int          len;
        seq[0] = 1'b0;
        for (int i = 0; i < nbits; i++) seq[1+i] = data[i];
        len = nbits + 1;
        if (has_par) begin
            seq[len] = par;
            len++;
        end
        seq[len] = stop;
        len++;
        send_bits(sel12, seq, len, half, glitch_at);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q8.size() != 0 || q12.size() != 0) && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        chk({tag, "_drained"}, q8.size() + q12.size(), 0);
    endtask

    task automatic frame8(input string tag, input logic [7:0] d, input logic par, input logic stop,
                          input int glitch_at, input logic [7:0] ew, input logic ep, input logic ef);
        int d0 = n_done8;
        exp_t e;
        e.word = {8'd0, ew};
        e.perr = ep;
        e.ferr = ef;
        q8.push_back(e);
        send_frame(1'b0, {8'd0, d}, 8, 1'b1, par, stop, 10, glitch_at);
        drain(tag);
        chk({tag, "_done_cnt"}, n_done8 - d0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rv;
        logic [7:0]  prev_word;
        int          t0, d0, n;
        exp_t        e;

        repeat (3) @(negedge sysclk);
        chk("rst_word8", {24'd0, word8}, 0);
        chk("rst_word12", {20'd0, word12}, 0);
        chk("rst_done8", {31'd0, done8}, 0);
        chk("rst_busy8", {31'd0, busy8}, 0);
        chk("rst_tmo8", {31'd0, tmo8}, 0);
        chk("rst_flags8", {30'd0, perr8, ferr8}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge sysclk);

        frame8("a5_good",    8'hA5, 1'b1, 1'b1, -1, 8'hA5, 1'b0, 1'b0);
        frame8("a5_par_bad", 8'hA5, 1'b0, 1'b1, -1, 8'hA5, 1'b1, 1'b0);
        frame8("a5_stop0",   8'hA5, 1'b1, 1'b0, -1, 8'hA5, 1'b0, 1'b1);
        frame8("zero",       8'h00, odd_par(16'h00, 8), 1'b1, -1, 8'h00, 1'b0, 1'b0);
        frame8("ones",       8'hFF, odd_par(16'hFF, 8), 1'b1, -1, 8'hFF, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            rv = 8'($urandom_range(0, 255));
            frame8("rand", rv, odd_par({8'd0, rv}, 8), 1'b1, -1, rv, 1'b0, 1'b0);
        end
        chk("word_held", {24'd0, word8}, {24'd0, rv});

        // start + 3 data bits, then clk stays high
        prev_word = word8;
        d0 = n_done8;
        t0 = n_tmo8;
        send_bits(1'b0, 32'b0110, 4, 10, -1);
        chk("busy_mid_frame", {31'd0, busy8}, 1);
        n = 0;
        while (n_tmo8 == t0 && n < 3000) begin
            @(negedge sysclk);
            n++;
        end
        repeat (5) @(negedge sysclk);
        chk("tmo_pulses", n_tmo8 - t0, 1);
        chk("tmo_busy", {31'd0, busy8}, 0);
        chk("tmo_word", {24'd0, word8}, {24'd0, prev_word});
        chk("tmo_no_done", n_done8 - d0, 0);

        // reset in the middle of a frame
        send_bits(1'b0, 32'b101010, 6, 10, -1);
        rst_n = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("midrst_word", {24'd0, word8}, 0);
        chk("midrst_busy", {31'd0, busy8}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge sysclk);
        frame8("after_rst", 8'h3C, odd_par(16'h3C, 8), 1'b1, -1, 8'h3C, 1'b0, 1'b0);

        // clk glitch after data bit 2 (wire index 3)
`ifdef TAPPY_GLITCH_FILTER_EN
        frame8("glitch", 8'h5A, odd_par(16'h5A, 8), 1'b1, 3, 8'h5A, 1'b0, 1'b0);
`else
        frame8("glitch", 8'h5A, odd_par(16'h5A, 8), 1'b1, 3, 8'hB2, 1'b1, 1'b0);
`endif

        // 12-bit, no parity, different serial rate
        d0 = n_done12;
        e.word = 16'h0ABC; e.perr = 1'b0; e.ferr = 1'b0;
        q12.push_back(e);
        send_frame(1'b1, 16'h0ABC, 12, 1'b0, 1'b0, 1'b1, 14, -1);
        drain("abc12");
        e.word = 16'h0123; e.perr = 1'b0; e.ferr = 1'b1;
        q12.push_back(e);
        send_frame(1'b1, 16'h0123, 12, 1'b0, 1'b0, 1'b0, 14, -1);
        drain("stop0_12");
        chk("done12_cnt", n_done12 - d0, 2);

        // idle edge with dat=1 is ignored
        d0 = n_done12;
        dat12 = 1'b1;
        clk12 = 1'b0;
        repeat (8) @(negedge sysclk);
        chk("idle_edge_busy_low", {31'd0, busy12}, 0);
        clk12 = 1'b1;
        repeat (8) @(negedge sysclk);
        chk("idle_edge_busy", {31'd0, busy12}, 0);
        chk("idle_edge_no_done", n_done12 - d0, 0);
        chk("idle_edge_word", {20'd0, word12}, 32'h123);

        repeat (10) @(negedge sysclk);
        chk("final_queues", q8.size() + q12.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
